// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: N-requester arbiter feeding a registered issue stage in
// front of a single-port memory, with read-data return routed by port tag.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req_valid    per-port request valid
//   req_we       per-port write enable (0 = read)
//   req_addr     packed per-port addresses, port i at [i*AddrWidth +: AddrWidth]
//   req_wdata    packed per-port write data, port i at [i*DataWidth +: DataWidth]
//   req_ready    one-hot grant, combinational from req_valid and the rr pointer
//   mem_en       registered access strobe
//   mem_we       registered write enable
//   mem_addr     registered address
//   mem_wdata    registered write data
//   mem_rdata    memory read data, valid ReadLatency cycles after a read issue
//   rsp_valid    read response valid
//   rsp_port     port index that owns rsp_data
//   rsp_data     read data, pass-through of mem_rdata
module mem_port_arbiter #(
    parameter int unsigned NumPorts    = 4,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned ArbMode     = 1,
    parameter int unsigned ReadLatency = 1,
    localparam int unsigned PortIdW    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NumPorts-1:0]             req_valid,
    input  logic [NumPorts-1:0]             req_we,
    input  logic [NumPorts*AddrWidth-1:0]   req_addr,
    input  logic [NumPorts*DataWidth-1:0]   req_wdata,
    output logic [NumPorts-1:0]             req_ready,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [AddrWidth-1:0]            mem_addr,
    output logic [DataWidth-1:0]            mem_wdata,
    input  logic [DataWidth-1:0]            mem_rdata,
    output logic                            rsp_valid,
    output logic [PortIdW-1:0]              rsp_port,
    output logic [DataWidth-1:0]            rsp_data
);

    typedef struct packed {
        logic               valid;
        logic [PortIdW-1:0] port;
    } tag_t;

    logic [NumPorts-1:0]  gnt_c;
    logic [PortIdW-1:0]   win_idx;
    logic                 accept;
    logic                 sel_we;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_wdata;

    logic [PortIdW-1:0]   ptr_q, ptr_d;
    logic                 mem_en_q, mem_we_q;
    logic [AddrWidth-1:0] mem_addr_q;
    logic [DataWidth-1:0] mem_wdata_q;
    logic [PortIdW-1:0]   iss_port_q;
    tag_t                 tag_d;
    tag_t                 tag_q [ReadLatency];

    // Winner selection. Round-robin is done in two passes: first the ports at
    // or above the pointer, then (wrapping) the lowest valid port overall.
    always_comb begin
        gnt_c   = '0;
        win_idx = '0;
        accept  = 1'b0;
        if (ArbMode == 0 || NumPorts == 1) begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
                if (!accept && req_valid[i]) begin
                    accept   = 1'b1;
                    gnt_c[i] = 1'b1;
                    win_idx  = PortIdW'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
                if (!accept && req_valid[i] && (i >= 32'(ptr_q))) begin
                    accept   = 1'b1;
                    gnt_c[i] = 1'b1;
                    win_idx  = PortIdW'(i);
                end
            end
            for (int unsigned i = 0; i < NumPorts; i++) begin
                if (!accept && req_valid[i]) begin
                    accept   = 1'b1;
                    gnt_c[i] = 1'b1;
                    win_idx  = PortIdW'(i);
                end
            end
        end
    end

    assign req_ready = gnt_c;

    // Pointer moves past the winner on every accept, otherwise holds.
    always_comb begin
        ptr_d = ptr_q;
        if (NumPorts == 1 || ArbMode == 0) begin
            ptr_d = '0;
        end else if (accept) begin
            if (win_idx == PortIdW'(NumPorts - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + PortIdW'(1);
            end
        end
    end

    // Payload mux driven by the one-hot grant.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (gnt_c[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*AddrWidth +: AddrWidth];
                sel_wdata = req_wdata[i*DataWidth +: DataWidth];
            end
        end
    end

    // Issue stage: address/data hold when idle so the memory bus stays quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            iss_port_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            mem_en_q <= accept;
            mem_we_q <= accept & sel_we;
            if (accept) begin
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
                iss_port_q  <= win_idx;
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Tag entering the return pipe in the cycle the memory sees the access.
    always_comb begin
        tag_d       = '0;
        tag_d.valid = mem_en_q & ~mem_we_q;
        tag_d.port  = iss_port_q;
    end

    // Return-tag shift register, aligned with the memory read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ReadLatency; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int unsigned i = 1; i < ReadLatency; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign rsp_valid = tag_q[ReadLatency-1].valid;
    assign rsp_port  = tag_q[ReadLatency-1].port;
    assign rsp_data  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance with a 3-cycle
// memory model and a fixed-priority instance share the same request inputs.
module tb_mem_port_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_we;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;

    logic [3:0]   req_ready_a, req_ready_b;
    logic         mem_en_a, mem_en_b, mem_we_a, mem_we_b;
    logic [31:0]  mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b;
    logic [31:0]  mem_rdata_a, mem_rdata_b;
    logic         rsp_valid_a, rsp_valid_b;
    logic [1:0]   rsp_port_a, rsp_port_b;
    logic [31:0]  rsp_data_a, rsp_data_b;
    logic [31:0]  rd_pipe [3];

    int checks;
    int failures;

    mem_port_arbiter #(.NumPorts(4), .AddrWidth(32), .DataWidth(32),
                       .ArbMode(1), .ReadLatency(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .rsp_valid(rsp_valid_a),
        .rsp_port(rsp_port_a), .rsp_data(rsp_data_a)
    );

    mem_port_arbiter #(.NumPorts(4), .AddrWidth(32), .DataWidth(32),
                       .ArbMode(0), .ReadLatency(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .rsp_valid(rsp_valid_b),
        .rsp_port(rsp_port_b), .rsp_data(rsp_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h40) return 32'h0000_DEAD;
        return {16'hA5A5, a[15:0]};
    endfunction

    // Memory model for instance A: read data appears 3 cycles after the access.
    always @(posedge clk) begin
        rd_pipe[0] <= (mem_en_a && !mem_we_a) ? mem_f(mem_addr_a) : 32'h0;
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end
    assign mem_rdata_a = rd_pipe[2];
    assign mem_rdata_b = 32'h0;

    task automatic set_port(input int i, input logic v, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
        req_valid[i] = v;
        req_we[i]    = w;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic clr_ports();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        clr_ports();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) set_port(i, 1'b1, 1'b1, 32'h100 + 32'(i*16), 32'hA0 + 32'(i));
        next_cycle();
        @(negedge clk);
        checks++; if (req_ready_a !== 4'b0001) begin failures++; $display("FAIL t1_ready_a_in_reset got=%b exp=0001", req_ready_a); end
        checks++; if (req_ready_b !== 4'b0001) begin failures++; $display("FAIL t1_ready_b_in_reset got=%b exp=0001", req_ready_b); end
        checks++; if (mem_en_a !== 1'b0) begin failures++; $display("FAIL t1_mem_en_in_reset got=%b exp=0", mem_en_a); end
        checks++; if (mem_we_a !== 1'b0) begin failures++; $display("FAIL t1_mem_we_in_reset got=%b exp=0", mem_we_a); end
        checks++; if (mem_addr_a !== 32'h0) begin failures++; $display("FAIL t1_mem_addr_in_reset got=%h exp=0", mem_addr_a); end
        checks++; if (rsp_valid_a !== 1'b0) begin failures++; $display("FAIL t1_rsp_valid_in_reset got=%b exp=0", rsp_valid_a); end
        checks++; if (rsp_port_a !== 2'd0) begin failures++; $display("FAIL t1_rsp_port_in_reset got=%0d exp=0", rsp_port_a); end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (mem_en_a !== 1'b0) begin failures++; $display("FAIL t1_mem_en_after_release got=%b exp=0", mem_en_a); end
        checks++; if (req_ready_a !== 4'b0001) begin failures++; $display("FAIL t1_ready_after_release got=%b exp=0001", req_ready_a); end
        next_cycle();
        clr_ports();
        @(negedge clk);
        checks++; if (mem_en_a !== 1'b1) begin failures++; $display("FAIL t1_first_issue_en got=%b exp=1", mem_en_a); end
        checks++; if (mem_we_a !== 1'b1) begin failures++; $display("FAIL t1_first_issue_we got=%b exp=1", mem_we_a); end
        checks++; if (mem_addr_a !== 32'h100) begin failures++; $display("FAIL t1_first_issue_addr got=%h exp=100", mem_addr_a); end
        checks++; if (mem_wdata_a !== 32'hA0) begin failures++; $display("FAIL t1_first_issue_wdata got=%h exp=a0", mem_wdata_a); end
        checks++; if (mem_en_b !== 1'b1) begin failures++; $display("FAIL t1_first_issue_en_b got=%b exp=1", mem_en_b); end
        next_cycle();
        @(negedge clk);
        checks++; if (mem_en_a !== 1'b0 || mem_we_a !== 1'b0) begin failures++; $display("FAIL t1_idle_en_we got=%b%b exp=00", mem_en_a, mem_we_a); end
        checks++; if (mem_addr_a !== 32'h100) begin failures++; $display("FAIL t1_idle_addr_hold got=%h exp=100", mem_addr_a); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_rdy;
        logic [31:0] exp_addr;
        do_reset();
        for (int i = 0; i < 4; i++) set_port(i, 1'b1, 1'b0, 32'h200 + 32'(i*4), 32'h0);
        for (int k = 0; k < 12; k++) begin
            if (k == 8) clr_ports();
            @(negedge clk);
            exp_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
            checks++; if (req_ready_a !== exp_rdy) begin failures++; $display("FAIL t2_grant k=%0d got=%b exp=%b", k, req_ready_a, exp_rdy); end
            if (k >= 1 && k <= 8) begin
                exp_addr = 32'h200 + 32'(((k - 1) % 4) * 4);
                checks++; if (mem_en_a !== 1'b1 || mem_addr_a !== exp_addr) begin failures++; $display("FAIL t2_issue k=%0d got en=%b addr=%h exp en=1 addr=%h", k, mem_en_a, mem_addr_a, exp_addr); end
            end
            if (k >= 4) begin
                exp_addr = 32'h200 + 32'(((k - 4) % 4) * 4);
                checks++; if (rsp_valid_a !== 1'b1 || rsp_port_a !== 2'((k - 4) % 4) || rsp_data_a !== mem_f(exp_addr)) begin
                    failures++; $display("FAIL t2_rsp k=%0d got v=%b p=%0d d=%h exp v=1 p=%0d d=%h", k, rsp_valid_a, rsp_port_a, rsp_data_a, (k - 4) % 4, mem_f(exp_addr));
                end
            end else begin
                checks++; if (rsp_valid_a !== 1'b0) begin failures++; $display("FAIL t2_rsp_early k=%0d got=%b exp=0", k, rsp_valid_a); end
            end
            next_cycle();
        end
    endtask

    task automatic test_fixed_priority();
        logic [3:0]  exp_rr;
        logic [31:0] exp_addr;
        do_reset();
        set_port(1, 1'b1, 1'b1, 32'h300, 32'h11);
        set_port(3, 1'b1, 1'b1, 32'h3C0, 32'h33);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (req_ready_b !== 4'b0010) begin failures++; $display("FAIL t3_fixed_grant k=%0d got=%b exp=0010", k, req_ready_b); end
            exp_rr = (k % 2 == 0) ? 4'b0010 : 4'b1000;
            checks++; if (req_ready_a !== exp_rr) begin failures++; $display("FAIL t3_rr_alternate k=%0d got=%b exp=%b", k, req_ready_a, exp_rr); end
            if (k >= 1) begin
                checks++; if (mem_addr_b !== 32'h300) begin failures++; $display("FAIL t3_fixed_addr k=%0d got=%h exp=300", k, mem_addr_b); end
                exp_addr = (k % 2 == 1) ? 32'h300 : 32'h3C0;
                checks++; if (mem_addr_a !== exp_addr) begin failures++; $display("FAIL t3_rr_addr k=%0d got=%h exp=%h", k, mem_addr_a, exp_addr); end
            end
            next_cycle();
        end
        clr_ports();
    endtask

    task automatic test_read_latency();
        do_reset();
        set_port(2, 1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        checks++; if (req_ready_a !== 4'b0100) begin failures++; $display("FAIL t4_grant got=%b exp=0100", req_ready_a); end
        next_cycle();
        clr_ports();
        for (int m = 1; m <= 5; m++) begin
            @(negedge clk);
            checks++; if (mem_en_a !== (m == 1)) begin failures++; $display("FAIL t4_mem_en m=%0d got=%b exp=%b", m, mem_en_a, m == 1); end
            checks++; if (rsp_valid_a !== (m == 4)) begin failures++; $display("FAIL t4_rsp_valid m=%0d got=%b exp=%b", m, rsp_valid_a, m == 4); end
            if (m == 4) begin
                checks++; if (rsp_port_a !== 2'd2) begin failures++; $display("FAIL t4_rsp_port got=%0d exp=2", rsp_port_a); end
                checks++; if (rsp_data_a !== 32'hDEAD) begin failures++; $display("FAIL t4_rsp_data got=%h exp=dead", rsp_data_a); end
            end
            next_cycle();
        end
    endtask

    task automatic test_change_while_waiting();
        do_reset();
        set_port(0, 1'b1, 1'b0, 32'h400, 32'h0);
        set_port(2, 1'b1, 1'b0, 32'h111, 32'h0);
        @(negedge clk);
        checks++; if (req_ready_a !== 4'b0001) begin failures++; $display("FAIL tc_first_grant got=%b exp=0001", req_ready_a); end
        next_cycle();
        set_port(0, 1'b0, 1'b0, 32'h400, 32'h0);
        set_port(2, 1'b1, 1'b1, 32'h222, 32'h5A5A);
        @(negedge clk);
        checks++; if (req_ready_a !== 4'b0100) begin failures++; $display("FAIL tc_second_grant got=%b exp=0100", req_ready_a); end
        next_cycle();
        clr_ports();
        @(negedge clk);
        checks++; if (mem_addr_a !== 32'h222 || mem_we_a !== 1'b1 || mem_wdata_a !== 32'h5A5A) begin
            failures++; $display("FAIL tc_accept_values got addr=%h we=%b wd=%h exp addr=222 we=1 wd=5a5a", mem_addr_a, mem_we_a, mem_wdata_a);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        do_reset();
        set_port(0, 1'b1, 1'b1, 32'h10, 32'h1234);
        @(negedge clk);
        checks++; if (req_ready_a !== 4'b0001) begin failures++; $display("FAIL t5_grant0 got=%b exp=0001", req_ready_a); end
        next_cycle();
        set_port(0, 1'b0, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        checks++; if (req_ready_a !== 4'b0010) begin failures++; $display("FAIL t5_grant1 got=%b exp=0010", req_ready_a); end
        checks++; if (mem_en_a !== 1'b1 || mem_we_a !== 1'b1 || mem_wdata_a !== 32'h1234) begin failures++; $display("FAIL t5_write_issue got en=%b we=%b wd=%h exp 1 1 1234", mem_en_a, mem_we_a, mem_wdata_a); end
        next_cycle();
        set_port(1, 1'b0, 1'b0, 32'h20, 32'h0);
        set_port(0, 1'b1, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        checks++; if (req_ready_a !== 4'b0001) begin failures++; $display("FAIL t5_grant2 got=%b exp=0001", req_ready_a); end
        checks++; if (mem_en_a !== 1'b1 || mem_we_a !== 1'b0 || mem_addr_a !== 32'h20) begin failures++; $display("FAIL t5_read1_issue got en=%b we=%b a=%h exp 1 0 20", mem_en_a, mem_we_a, mem_addr_a); end
        next_cycle();
        clr_ports();
        @(negedge clk);
        checks++; if (mem_en_a !== 1'b1 || mem_we_a !== 1'b0 || mem_addr_a !== 32'h30) begin failures++; $display("FAIL t5_read0_issue got en=%b we=%b a=%h exp 1 0 30", mem_en_a, mem_we_a, mem_addr_a); end
        next_cycle();
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            exp_v = (c == 5 || c == 6);
            checks++; if (rsp_valid_a !== exp_v) begin failures++; $display("FAIL t5_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid_a, exp_v); end
            if (c == 5) begin
                checks++; if (rsp_port_a !== 2'd1 || rsp_data_a !== mem_f(32'h20)) begin failures++; $display("FAIL t5_rsp_first got p=%0d d=%h exp p=1 d=%h", rsp_port_a, rsp_data_a, mem_f(32'h20)); end
            end
            if (c == 6) begin
                checks++; if (rsp_port_a !== 2'd0 || rsp_data_a !== mem_f(32'h30)) begin failures++; $display("FAIL t5_rsp_second got p=%0d d=%h exp p=0 d=%h", rsp_port_a, rsp_data_a, mem_f(32'h30)); end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        set_port(0, 1'b1, 1'b0, 32'h50, 32'h0);
        @(negedge clk);
        checks++; if (req_ready_a !== 4'b0001) begin failures++; $display("FAIL t6_grant0 got=%b exp=0001", req_ready_a); end
        next_cycle();
        set_port(0, 1'b0, 1'b0, 32'h50, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h60, 32'h0);
        @(negedge clk);
        checks++; if (req_ready_a !== 4'b0010) begin failures++; $display("FAIL t6_grant1 got=%b exp=0010", req_ready_a); end
        next_cycle();
        clr_ports();
        @(negedge clk);
        checks++; if (mem_en_a !== 1'b1 || mem_addr_a !== 32'h60) begin failures++; $display("FAIL t6_second_read got en=%b a=%h exp 1 60", mem_en_a, mem_addr_a); end
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid_a !== 1'b0 || mem_en_a !== 1'b0) begin failures++; $display("FAIL t6_in_reset got v=%b en=%b exp 0 0", rsp_valid_a, mem_en_a); end
        next_cycle();
        rst_n = 1'b1;
        set_port(1, 1'b1, 1'b0, 32'h70, 32'h0);
        set_port(2, 1'b1, 1'b0, 32'h80, 32'h0);
        @(negedge clk);
        checks++; if (req_ready_a !== 4'b0010) begin failures++; $display("FAIL t6_ptr_restart got=%b exp=0010", req_ready_a); end
        checks++; if (rsp_valid_a !== 1'b0) begin failures++; $display("FAIL t6_stale_rsp c=4 got=%b exp=0", rsp_valid_a); end
        next_cycle();
        clr_ports();
        for (int c = 5; c <= 8; c++) begin
            @(negedge clk);
            if (c == 5) begin
                checks++; if (mem_addr_a !== 32'h70) begin failures++; $display("FAIL t6_post_addr got=%h exp=70", mem_addr_a); end
            end
            checks++; if (rsp_valid_a !== (c == 8)) begin failures++; $display("FAIL t6_rsp c=%0d got=%b exp=%b", c, rsp_valid_a, c == 8); end
            if (c == 8) begin
                checks++; if (rsp_port_a !== 2'd1) begin failures++; $display("FAIL t6_rsp_port got=%0d exp=1", rsp_port_a); end
            end
            next_cycle();
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_read_latency();
        test_change_while_waiting();
        test_back_to_back();
        test_reset_mid_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
